// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Combinational only: no latency.
// No handshake; pure declarations.
package serial_add_pkg;

  // Controller states; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fulladd.sv
// One-bit full-adder cell, time-multiplexed across bit positions by the controller.
// Purely combinational: zero latency.
// No handshake; outputs follow inputs.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: sequences one full-adder cell LSB-first over WIDTH cycles.
// Latency: done rises WIDTH cycles after the accepting edge; one result per WIDTH+2 cycles.
// start is only sampled in IDLE; requests while busy are dropped, not queued.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   acc;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               cell_sum;
  logic               cell_cout;
  logic               last_bit;

  // The single shared adder cell always looks at the current LSBs and running carry.
  fulladd u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // FSM, datapath shift registers and registered outputs in one sequential block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at acc[0].
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= {cell_sum, acc[WIDTH-1:1]};
          carry <= cell_cout;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum   <= {cell_sum, acc[WIDTH-1:1]};
            cout  <= cell_cout;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
// Directed vectors, multi-cycle corner sequences and random checks vs an arithmetic model.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        cin8, cin16;
  logic        busy8, done8, cout8;
  logic        busy16, done16, cout16;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation: latency counted in edges after the accept edge.
  task automatic run_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic [7:0] rs, output logic rc,
                         output int lat, output int bcyc);
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = -1; bcyc = 0; rs = '0; rc = 1'b0;
    if (busy8) bcyc++;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (done8) begin
        if (lat < 0) lat = i;
        rs = sum8;
        rc = cout8;
      end
      if (busy8) bcyc++;
      else break;
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0]  rs;
    logic        rc;
    int          lat, bcyc, ndone;
    int          dt[3];
    logic [8:0]  exp9;
    logic [16:0] exp17;
    int          l8, l16;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic        c8, c16;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    tick();
    tick();
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_done", 32'(done8), 32'd0);
    check("reset_sum",  32'(sum8),  32'd0);
    check("reset_cout", 32'(cout8), 32'd0);
    rst = 1'b0;
    tick();

    // Directed table; each result must also hold for a few idle cycles.
    for (int v = 0; v < 6; v++) begin
      run_op8(vecs[v].a, vecs[v].b, vecs[v].cin, rs, rc, lat, bcyc);
      check("vec_sum",  32'(rs), 32'(vecs[v].exp_sum));
      check("vec_cout", 32'(rc), 32'(vecs[v].exp_cout));
      check("vec_latency", 32'(lat), 32'd8);
      check("vec_busy_cycles", 32'(bcyc), 32'd9);
      repeat (3) tick();
      check("hold_sum",  32'(sum8),  32'(vecs[v].exp_sum));
      check("hold_cout", 32'(cout8), 32'(vecs[v].exp_cout));
    end

    // start pulses in RUN (cycle 3) and DONE (cycle 9) must be dropped.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0; rs = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3 || i == 9) begin
        a8 = 8'hEE; b8 = 8'hEE; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        ndone++;
        rs = sum8;
      end
      tick();
    end
    start8 = 1'b0;
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_sum", 32'(rs), 32'h33);
    check("ignore_idle", 32'(busy8), 32'd0);

    // start held high: accepts every WIDTH+2 cycles.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done8) begin
        if (ndone < 3) dt[ndone] = i;
        ndone++;
      end
    end
    start8 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy8) break;
      tick();
    end
    check("hold_start_done_count", 32'(ndone), 32'd3);
    if (ndone >= 3) begin
      check("hold_start_spacing0", 32'(dt[1] - dt[0]), 32'd10);
      check("hold_start_spacing1", 32'(dt[2] - dt[1]), 32'd10);
    end
    check("hold_start_sum", 32'(sum8), 32'h30);
    check("hold_start_idle", 32'(busy8), 32'd0);

    // Reset in the middle of RUN discards the operation.
    a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midreset_busy", 32'(busy8), 32'd0);
    check("midreset_done", 32'(done8), 32'd0);
    check("midreset_sum",  32'(sum8),  32'd0);
    check("midreset_cout", 32'(cout8), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      tick();
    end
    check("midreset_no_done", 32'(ndone), 32'd0);
    run_op8(8'h12, 8'h34, 1'b0, rs, rc, lat, bcyc);
    check("post_reset_sum", 32'(rs), 32'h46);
    check("post_reset_cout", 32'(rc), 32'd0);
    check("post_reset_latency", 32'(lat), 32'd8);

    // Random operands on both widths against plain integer addition.
    for (int n = 0; n < 1000; n++) begin
      a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      exp9  = 9'(a8)  + 9'(b8)  + 9'(cin8);
      exp17 = 17'(a16) + 17'(b16) + 17'(cin16);
      start8 = 1'b1; start16 = 1'b1;
      tick();
      start8 = 1'b0; start16 = 1'b0;
      a8  = 8'($urandom);  b8  = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      l8 = -1; l16 = -1;
      s8 = '0; s16 = '0; c8 = 1'b0; c16 = 1'b0;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (done8 && l8 < 0) begin
          l8 = i; s8 = sum8; c8 = cout8;
        end
        if (done16 && l16 < 0) begin
          l16 = i; s16 = sum16; c16 = cout16;
        end
        if (l8 >= 0 && l16 >= 0 && !busy8 && !busy16) break;
      end
      check("rand8_result",   32'({c8, s8}),   32'(exp9));
      check("rand8_latency",  32'(l8),         32'd8);
      check("rand16_result",  32'({c16, s16}), 32'(exp17));
      check("rand16_latency", 32'(l16),        32'd16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
